// File: rtl/ad5662_rx.sv
// AD5662-style 24-bit serial receiver: synchronizes sclk/sync_/sdi into clk, shifts
// frames MSB first and publishes the DAC word, power-down bits and status strobes.
module ad5662_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        sync_,
  input  logic        sdi,
  output logic [15:0] dac,
  output logic [1:0]  pd,
  output logic        valid,
  output logic        err,
  output logic        resv_nz,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Edge detection is held off until the chains hold real pin samples, so a
  // sync_ already low at reset release cannot look like a fresh falling edge.
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sync_sync_q, sync_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   sync_hist_q, sync_hist_d;
  logic [2:0]             settle_q, settle_d;

  state_t                 state_q, state_d;
  logic [23:0]            sr_q, sr_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   load_q, load_d;
  logic                   abort_q, abort_d;

  logic [15:0]            dac_q, dac_d;
  logic [1:0]             pd_q, pd_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   resv_nz_q, resv_nz_d;
  logic                   busy_q, busy_d;

  logic                   sclk_s, sync_s, sdi_s;
  logic                   sclk_fall, sync_fall, sync_rise;
  logic                   overrun_hit;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sync_s    = sync_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_hist_q & ~sclk_s;
  assign sync_fall = sync_hist_q & ~sync_s & (settle_q == SETTLE);
  assign sync_rise = ~sync_hist_q & sync_s;

  // Synchronizer chains, edge history and post-reset settle counter
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sync_sync_d = {sync_sync_q[SYNC_STAGES-2:0], sync_};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    sclk_hist_d = sclk_s;
    sync_hist_d = sync_s;
    settle_d    = settle_q;
    if (settle_q != SETTLE) begin
      settle_d = settle_q + 3'd1;
    end else begin
      settle_d = settle_q;
    end
  end

  // Next-state logic; a 24th edge coinciding with the sync_ rise still completes the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sync_fall) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sclk_fall && (bit_cnt_q == 5'd23)) begin
          state_d = sync_rise ? IDLE : DONE;
        end else if (sync_rise) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (sync_rise) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath plus load/abort requests for the output stage
  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    overrun_d   = overrun_q;
    load_d      = 1'b0;
    abort_d     = 1'b0;
    overrun_hit = overrun_q | sclk_fall;
    case (state_q)
      IDLE: begin
        if (sync_fall) begin
          sr_d      = 24'h00_0000;
          bit_cnt_d = 5'd0;
          overrun_d = 1'b0;
        end else begin
          sr_d      = sr_q;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          sr_d      = {sr_q[22:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else begin
          sr_d      = sr_q;
        end
        if (sclk_fall && (bit_cnt_q == 5'd23)) begin
          load_d  = 1'b1;
        end else if (sync_rise) begin
          abort_d = 1'b1;
        end else begin
          load_d  = 1'b0;
        end
      end
      DONE: begin
        overrun_d = overrun_hit;
        if (sync_rise) begin
          abort_d = overrun_hit;
        end else begin
          abort_d = 1'b0;
        end
      end
      default: begin
        sr_d      = sr_q;
      end
    endcase
  end

  // Output stage: one clk after the frame completes, publish word and strobes
  always_comb begin
    dac_d     = dac_q;
    pd_d      = pd_q;
    resv_nz_d = resv_nz_q;
    valid_d   = load_q;
    err_d     = abort_q & ~load_q;
    busy_d    = (state_d != IDLE);
    if (load_q) begin
      dac_d     = sr_q[15:0];
      pd_d      = sr_q[17:16];
      resv_nz_d = |sr_q[23:18];
    end else begin
      dac_d     = dac_q;
    end
  end

  // Synchronizer and edge-history registers; idle-high pins reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      sync_sync_q <= '1;
      sdi_sync_q  <= '0;
      sclk_hist_q <= 1'b1;
      sync_hist_q <= 1'b1;
      settle_q    <= 3'd0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sync_sync_q <= sync_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      sync_hist_q <= sync_hist_d;
      settle_q    <= settle_d;
    end
  end

  // FSM state and frame datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= 24'h00_0000;
      bit_cnt_q <= 5'd0;
      overrun_q <= 1'b0;
      load_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      overrun_q <= overrun_d;
      load_q    <= load_d;
      abort_q   <= abort_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q     <= 16'h0000;
      pd_q      <= 2'b00;
      resv_nz_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dac_q     <= dac_d;
      pd_q      <= pd_d;
      resv_nz_q <= resv_nz_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign dac     = dac_q;
  assign pd      = pd_q;
  assign resv_nz = resv_nz_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ad5662_rx.sv
// Scoreboard bench for ad5662_rx: frames push expected words, a monitor pops them on valid.
module tb_ad5662_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        sync_ = 1'b1;
  logic        sdi = 1'b0;
  logic [15:0] dac;
  logic [1:0]  pd;
  logic        valid, err, resv_nz, busy;

  typedef struct {
    logic [15:0] dac;
    logic [1:0]  pd;
    logic        resv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   err_exp = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   lat;

  ad5662_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .sync_  (sync_),
    .sdi    (sdi),
    .dac    (dac),
    .pd     (pd),
    .valid  (valid),
    .err    (err),
    .resv_nz(resv_nz),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every valid and accounts for every err
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && err) begin
        compared++; mismatched++;
        $display("FAIL valid_err_overlap: valid=%b err=%b, required not both high", valid, err);
      end
      if (valid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_valid: valid=1 dac=%h, required no valid", dac);
        end else begin
          mon_e = exp_q.pop_front();
          if (dac !== mon_e.dac) begin
            mismatched++;
            $display("FAIL dac: got %h, required %h", dac, mon_e.dac);
          end
          compared++;
          if (pd !== mon_e.pd) begin
            mismatched++;
            $display("FAIL pd: got %b, required %b", pd, mon_e.pd);
          end
          compared++;
          if (resv_nz !== mon_e.resv) begin
            mismatched++;
            $display("FAIL resv_nz: got %b, required %b", resv_nz, mon_e.resv);
          end
          compared++;
          lat = cyc - last_fall_cyc;
          if (lat < SYNC_STAGES + 1 || lat > SYNC_STAGES + 3) begin
            mismatched++;
            $display("FAIL latency: got %0d cycles, required %0d +/-1", lat, SYNC_STAGES + 2);
          end
        end
      end
      if (err) begin
        compared++;
        if (err_exp == 0) begin
          mismatched++;
          $display("FAIL unexpected_err: err=1, required no err pulse");
        end else begin
          err_exp--;
        end
      end
    end
  end

  task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
    @(posedge clk); #1 sync_ = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_open: got %b, required 1", busy);
    end
    for (int i = 0; i < n; i++) begin
      sdi = bits[n-1-i];
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b0;
      if (i == 23) last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    #1 sync_ = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string name, input logic [15:0] want_dac);
    repeat (12) @(posedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_missing_valid: %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    compared++;
    if (err_exp != 0) begin
      mismatched++;
      $display("FAIL %s_missing_err: %0d pending, required 0", name, err_exp);
      err_exp = 0;
    end
    compared++;
    if (dac !== want_dac) begin
      mismatched++;
      $display("FAIL %s_dac_final: got %h, required %h", name, dac, want_dac);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_busy_idle: got %b, required 0", name, busy);
    end
  endtask

  task automatic check_zero(input string name);
    compared++;
    if ({dac, pd, valid, err, resv_nz, busy} !== 22'd0) begin
      mismatched++;
      $display("FAIL %s: dac=%h pd=%b valid=%b err=%b resv_nz=%b busy=%b, required all 0",
               name, dac, pd, valid, err, resv_nz, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    exp_q.push_back('{16'h8123, 2'b00, 1'b0});
    send_frame({8'h00, 24'h00_8123}, 24, 30);
    check_end("frame_8123", 16'h8123);
    exp_q.push_back('{16'hFFFF, 2'b11, 1'b0});
    send_frame({8'h00, 24'h03_FFFF}, 24, 30);
    check_end("frame_03ffff", 16'hFFFF);
    exp_q.push_back('{16'h0001, 2'b00, 1'b1});
    send_frame({8'h00, 24'hFC_0001}, 24, 30);
    check_end("frame_fc0001", 16'h0001);
  endtask

  task automatic test_abort();
    err_exp++;
    send_frame(32'h0000_02AB, 10, 30);
    check_end("abort10", 16'h0001);
  endtask

  task automatic test_overrun();
    exp_q.push_back('{16'h5A3C, 2'b01, 1'b1});
    err_exp++;
    send_frame({6'd0, 24'hA5_5A3C, 2'b11}, 26, 30);
    check_end("overrun26", 16'h5A3C);
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{16'h0001, 2'b00, 1'b0});
    exp_q.push_back('{16'h0002, 2'b00, 1'b0});
    send_frame({8'h00, 24'h00_0001}, 24, SYNC_STAGES + 4);
    send_frame({8'h00, 24'h00_0002}, 24, 30);
    check_end("back_to_back", 16'h0002);
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1 sync_ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sdi = i[0];
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("midframe_in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sdi = ~sdi;
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 sclk = 1'b1;
    end
    check_zero("midframe_no_activity");
    sync_ = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_zero("midframe_sync_release");
    exp_q.push_back('{16'h1234, 2'b00, 1'b0});
    send_frame({8'h00, 24'h00_1234}, 24, 30);
    check_end("after_reset_1234", 16'h1234);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
